// File: rtl/key_state_tracker.sv
// PS/2 scan-code tracker: decodes make/break sequences into a 20-bit key-state vector for 4 players.
// Define FIRE_ONESHOT_EN to make the fire bits single-cycle pulses on a fresh press.
module key_state_tracker (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  code,
    input  logic        code_valid,
    input  logic        clear,
    output logic [19:0] out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dir_q, dir_d;
    logic [3:0]  fire_q, fire_d;

    logic        is_ext;
    logic        is_break;
    logic        complete;
    logic        key_hit;
    logic [4:0]  key_idx;

    assign is_ext   = (state_q == EXT) || (state_q == EXT_BRK);
    assign is_break = (state_q == BRK) || (state_q == EXT_BRK);
    assign complete = code_valid && !clear && (code != 8'hE0) && (code != 8'hF0);

    // Index 0..15 are direction bits, 16..19 fire; the extended flag is part of the match key.
    always_comb begin
        key_hit = 1'b1;
        key_idx = 5'd0;
        case ({is_ext, code})
            9'h01D: key_idx = 5'd0;
            9'h01B: key_idx = 5'd1;
            9'h01C: key_idx = 5'd2;
            9'h023: key_idx = 5'd3;
            9'h029: key_idx = 5'd16;
            9'h175: key_idx = 5'd4;
            9'h172: key_idx = 5'd5;
            9'h16B: key_idx = 5'd6;
            9'h174: key_idx = 5'd7;
            9'h114: key_idx = 5'd17;
            9'h043: key_idx = 5'd8;
            9'h042: key_idx = 5'd9;
            9'h03B: key_idx = 5'd10;
            9'h04B: key_idx = 5'd11;
            9'h04C: key_idx = 5'd18;
            9'h075: key_idx = 5'd12;
            9'h073: key_idx = 5'd13;
            9'h06B: key_idx = 5'd14;
            9'h074: key_idx = 5'd15;
            9'h070: key_idx = 5'd19;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (code_valid) begin
            if (code == 8'hE0) begin
                state_d = EXT;
            end else if (code == 8'hF0) begin
                state_d = is_ext ? EXT_BRK : BRK;
            end else begin
                state_d = IDLE;
            end
        end
    end

`ifdef FIRE_ONESHOT_EN
    logic [3:0] fire_held_q, fire_held_d;

    always_comb begin
        dir_d       = dir_q;
        fire_d      = 4'h0;
        fire_held_d = fire_held_q;
        if (clear) begin
            dir_d       = '0;
            fire_held_d = '0;
        end else if (complete && key_hit) begin
            if (!key_idx[4]) begin
                dir_d[key_idx[3:0]] = !is_break;
            end else if (is_break) begin
                fire_held_d[key_idx[1:0]] = 1'b0;
            end else if (!fire_held_q[key_idx[1:0]]) begin
                // Only a fresh press pulses; typematic repeats find the shadow bit already set.
                fire_held_d[key_idx[1:0]] = 1'b1;
                fire_d[key_idx[1:0]]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fire_held_q <= '0;
        end else begin
            fire_held_q <= fire_held_d;
        end
    end
`else
    always_comb begin
        dir_d  = dir_q;
        fire_d = fire_q;
        if (clear) begin
            dir_d  = '0;
            fire_d = '0;
        end else if (complete && key_hit) begin
            if (!key_idx[4]) begin
                dir_d[key_idx[3:0]] = !is_break;
            end else begin
                fire_d[key_idx[1:0]] = !is_break;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            dir_q   <= '0;
            fire_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fire_q  <= fire_d;
        end
    end

    assign out  = {fire_q, dir_q};
    assign busy = (state_q != IDLE);

endmodule

// File: doc/key_state_tracker.md
KEY_STATE_TRACKER -- requirements
Module: key_state_tracker

Interface
REQ-001 Ports: clk  in  1  system clock, 50 MHz; the only clock.
REQ-002 Ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 Ports: code  in  8  PS/2 scan-code byte from the keyboard receiver.
REQ-004 Ports: code_valid  in  1  one-cycle strobe; `code` is valid in that cycle.
REQ-005 Ports: clear  in  1  synchronous release of all keys.
REQ-006 Ports: out  out  20  key-state vector. Bits [4p+3:4p] are up/down/left/right for player p = 0..3. Bits [16+p] are fire for player p.
REQ-007 Ports: busy  out  1  high while a prefix byte (E0 and/or F0) is pending.

Function
REQ-008 The block SHALL decode these keys; all other codes are ignored:
- P0: W 1D, S 1B, A 1C, D 23, fire Space 29.
- P1: E0 75, E0 72, E0 6B, E0 74, fire E0 14 (right Ctrl).
- P2: I 43, K 42, J 3B, L 4B, fire 4C.
- P3: keypad 75, 73, 6B, 74, fire keypad 70.
REQ-009 A non-extended code SHALL NOT match an extended entry, and an extended code SHALL NOT match a non-extended entry (e.g. 75 is P3 up; E0 75 is P1 up).
REQ-010 The FSM SHALL have states IDLE, EXT, BRK, EXT_BRK; all transitions occur only on `code_valid`.
REQ-011 The FSM SHALL take these transitions:
- E0 from any state goes to EXT.
- F0 from IDLE or BRK goes to BRK; F0 from EXT or EXT_BRK goes to EXT_BRK.
- Any other byte completes the sequence and returns the FSM to IDLE.
REQ-012 A completing byte SHALL be interpreted as follows:
- In IDLE or EXT it is a make: set the mapped bit.
- In BRK or EXT_BRK it is a break: clear the mapped bit.
- The extended flag is set when the state is EXT or EXT_BRK.
REQ-013 `out` SHALL be registered and SHALL update exactly 1 cycle after the `code_valid` cycle of the completing byte.
REQ-014 A repeated make (typematic) of an already-held key SHALL leave its direction bit unchanged at 1.
REQ-015 A break for a key not held SHALL be a no-op.
REQ-016 Bytes E1, AA, FA, EE, FE, 00 and FF SHALL be treated as unmapped completing bytes: FSM to IDLE, `out` unchanged.
REQ-017 `busy` SHALL be 1 exactly when the FSM is not in IDLE.
REQ-018 `clear` SHALL, on the next edge, zero all 20 bits of `out` and force the FSM to IDLE.
REQ-019 If `clear` and `code_valid` are high in the same cycle, `clear` SHALL win and the byte SHALL be discarded.
REQ-020 Multiple keys SHALL be held simultaneously and independently; opposing directions (up and down) may both be 1, and resolving them is left to downstream logic.

Reset
REQ-021 When `resetn` = 0, asynchronously: `out` = 20'h00000, FSM = IDLE, `busy` = 0, and the fire-held shadow bits = 0.
REQ-022 A reset in the middle of a sequence (e.g. after E0 F0) SHALL discard the pending prefix; the next byte is decoded from IDLE.

Configuration
REQ-023 With `FIRE_ONESHOT_EN` defined:
- Bits [19:16] SHALL pulse high for exactly 1 cycle on a make of a fire key that is not already held.
- Typematic repeats SHALL NOT re-pulse.
- A per-player held shadow register SHALL track the fire keys and is cleared by break, `clear` or reset.
REQ-024 With `FIRE_ONESHOT_EN` undefined, bits [19:16] SHALL follow the held state exactly like the direction bits, and no shadow register exists.

Verification
REQ-025 Bytes 1D, then F0 1D -> `out[0]` = 1 one cycle after 1D; `out[0]` = 0 one cycle after the second 1D; `busy` = 1 only in the cycle between F0 and the second 1D.
REQ-026 Bytes E0 75, then 75 -> `out[4]` = 1 and `out[12]` = 1; then E0 F0 75 -> `out[4]` = 0 and `out[12]` still 1.
REQ-027 Bytes 29 29 29 (typematic) -> oneshot build: `out[16]` is a single 1-cycle pulse; non-oneshot build: `out[16]` = 1 until F0 29.
REQ-028 Hold 1D, 43 and 74, then assert `clear` in the same cycle as `code_valid` with code 23 -> `out` = 0 next cycle, `out[3]` never set, FSM in IDLE.
REQ-029 Send E0 F0, assert `resetn` low, release it, then send 1B -> `out[1]` = 1 (make, not break); `busy` = 0 immediately after reset.
REQ-030 Send 5A, E1 and AA -> `out` unchanged at 0 and `busy` = 0 after each byte.
